// File: rtl/cpu_hazard_pipe.sv
// Load-use hazard detector with Ex/Mem destination tracking and a saturating stall counter.
// Register 31 is hard-wired zero and never produces a hazard.
module cpu_hazard_pipe (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rd_Id,
    input  logic       regWrite_Id,
    input  logic       memRead_Id,
    input  logic [4:0] Reg_Aa,
    input  logic [4:0] Reg_Ab,
    input  logic       useAa_Id,
    input  logic       useAb_Id,
    input  logic       flush,
    output logic [4:0] Rd_Ex,
    output logic [4:0] Rd_Mem,
    output logic       writeEn_Ex,
    output logic       writeEn_Mem,
    output logic       memRead_Ex,
    output logic       stall,
    output logic [7:0] stall_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(255);

    logic [REG_W-1:0] rd_ex_q,  rd_ex_d;
    logic [REG_W-1:0] rd_mem_q, rd_mem_d;
    logic             we_ex_q,  we_ex_d;
    logic             mr_ex_q,  mr_ex_d;
    logic             we_mem_q, we_mem_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic             id_dst_real;
    logic             ex_load_real;
    logic             src_hit;
    logic             stall_c;

    // Hazard: a real load sits in Ex and decode reads its destination; flush wins.
    always_comb begin
        ex_load_real = mr_ex_q & we_ex_q & (rd_ex_q != ZERO_REG);
        src_hit      = (useAa_Id & (Reg_Aa == rd_ex_q)) | (useAb_Id & (Reg_Ab == rd_ex_q));
        stall_c      = ~flush & ex_load_real & src_hit;
    end

    // Next-state for both pipeline slots and the stall counter.
    always_comb begin
        id_dst_real = (Rd_Id != ZERO_REG);
        rd_ex_d     = ZERO_REG;
        we_ex_d     = 1'b0;
        mr_ex_d     = 1'b0;
        rd_mem_d    = rd_ex_q;
        we_mem_d    = we_ex_q;
        cnt_d       = cnt_q;

        if (!(flush || stall_c)) begin
            rd_ex_d = Rd_Id;
            we_ex_d = regWrite_Id & id_dst_real;
            mr_ex_d = memRead_Id  & id_dst_real;
        end

        if (stall_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ex_q  <= ZERO_REG;
            we_ex_q  <= 1'b0;
            mr_ex_q  <= 1'b0;
            rd_mem_q <= ZERO_REG;
            we_mem_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rd_ex_q  <= rd_ex_d;
            we_ex_q  <= we_ex_d;
            mr_ex_q  <= mr_ex_d;
            rd_mem_q <= rd_mem_d;
            we_mem_q <= we_mem_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Rd_Ex       = rd_ex_q;
    assign writeEn_Ex  = we_ex_q;
    assign memRead_Ex  = mr_ex_q;
    assign Rd_Mem      = rd_mem_q;
    assign writeEn_Mem = we_mem_q;
    assign stall       = stall_c;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_hazard_pipe.sv
// Bench for cpu_hazard_pipe: directed hazard scenarios plus random traffic
// compared every cycle against a two-slot pipeline model.
`timescale 1ns/1ps
module tb_cpu_hazard_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] Rd_Id, Reg_Aa, Reg_Ab;
    logic       regWrite_Id, memRead_Id, useAa_Id, useAb_Id, flush;
    logic [4:0] Rd_Ex, Rd_Mem;
    logic       writeEn_Ex, writeEn_Mem, memRead_Ex, stall;
    logic [7:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    cpu_hazard_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .Rd_Id(Rd_Id), .regWrite_Id(regWrite_Id), .memRead_Id(memRead_Id),
        .Reg_Aa(Reg_Aa), .Reg_Ab(Reg_Ab), .useAa_Id(useAa_Id), .useAb_Id(useAb_Id),
        .flush(flush),
        .Rd_Ex(Rd_Ex), .Rd_Mem(Rd_Mem), .writeEn_Ex(writeEn_Ex), .writeEn_Mem(writeEn_Mem),
        .memRead_Ex(memRead_Ex), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       mr;
    } slot_t;

    localparam slot_t BUB = '{rd: 5'd31, we: 1'b0, mr: 1'b0};

    // pipe[0] is the Ex slot, pipe[1] the Mem slot
    slot_t pipe [2];
    int    m_cnt;

    // Decode must wait if it reads a register a load in Ex has not yet delivered.
    function automatic logic model_stall();
        logic reads_it;
        if (flush) return 1'b0;
        if (!(pipe[0].mr && pipe[0].we) || pipe[0].rd == 5'd31) return 1'b0;
        reads_it = (useAa_Id && Reg_Aa == pipe[0].rd) || (useAb_Id && Reg_Ab == pipe[0].rd);
        return reads_it;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe[0] <= BUB;
            pipe[1] <= BUB;
            m_cnt   <= 0;
        end else begin
            pipe[1] <= pipe[0];
            if (model_stall()) m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            if (flush || model_stall())
                pipe[0] <= BUB;
            else
                pipe[0] <= '{rd: Rd_Id,
                             we: regWrite_Id && (Rd_Id != 5'd31),
                             mr: memRead_Id && (Rd_Id != 5'd31)};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd_ex",   32'(Rd_Ex),       32'(pipe[0].rd));
            chk("m_we_ex",   32'(writeEn_Ex),  32'(pipe[0].we));
            chk("m_mr_ex",   32'(memRead_Ex),  32'(pipe[0].mr));
            chk("m_rd_mem",  32'(Rd_Mem),      32'(pipe[1].rd));
            chk("m_we_mem",  32'(writeEn_Mem), 32'(pipe[1].we));
            chk("m_stall",   32'(stall),       32'(model_stall()));
            chk("m_cnt",     32'(stall_cnt),   32'(m_cnt));
        end
    end

    task automatic drive(input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [4:0] aa, input logic ua,
                         input logic [4:0] ab, input logic ub, input logic fl);
        Rd_Id = rd; regWrite_Id = rw; memRead_Id = mr;
        Reg_Aa = aa; useAa_Id = ua; Reg_Ab = ab; useAb_Id = ub; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = int'($urandom_range(0, 8));
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset_n = 1'b0;
        drive(5'd31, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        repeat (3) tick();
        chk_en = 1'b1;
        #1;
        chk("rst_rd_ex",  32'(Rd_Ex),       32'd31);
        chk("rst_rd_mem", 32'(Rd_Mem),      32'd31);
        chk("rst_we_ex",  32'(writeEn_Ex),  32'd0);
        chk("rst_cnt",    32'(stall_cnt),   32'd0);
        chk("rst_stall",  32'(stall),       32'd0);
        reset_n = 1'b1;
        tick();

        // load-use: one stall, bubble in Ex, load reaches Mem
        drive(5'd5, 1, 1, 5'd0, 0, 5'd0, 0, 0);
        tick();
        drive(5'd8, 1, 0, 5'd5, 1, 5'd0, 0, 0);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_rd_ex",   32'(Rd_Ex),       32'd31);
        chk("lu_rd_mem",  32'(Rd_Mem),      32'd5);
        chk("lu_we_mem",  32'(writeEn_Mem), 32'd1);
        chk("lu_stall2",  32'(stall),       32'd0);
        chk("lu_cnt",     32'(stall_cnt),   32'd1);
        tick();

        // ALU producer: forwarded, never stalls
        drive(5'd7, 1, 0, 5'd0, 0, 5'd0, 0, 0);
        tick();
        chk("alu_rd_ex", 32'(Rd_Ex), 32'd7);
        drive(5'd9, 1, 0, 5'd0, 0, 5'd7, 1, 0);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_rd_mem", 32'(Rd_Mem), 32'd7);

        // zero register load is inert
        drive(5'd31, 1, 1, 5'd0, 0, 5'd0, 0, 0);
        tick();
        chk("z_we_ex", 32'(writeEn_Ex), 32'd0);
        chk("z_mr_ex", 32'(memRead_Ex), 32'd0);
        drive(5'd2, 1, 0, 5'd31, 1, 5'd0, 0, 0);
        #1 chk("z_stall", 32'(stall), 32'd0);
        tick();

        // flush beats stall
        drive(5'd5, 1, 1, 5'd0, 0, 5'd0, 0, 0);
        tick();
        drive(5'd8, 1, 0, 5'd5, 1, 5'd0, 0, 1);
        #1 chk("fl_stall", 32'(stall), 32'd0);
        tick();
        chk("fl_rd_ex", 32'(Rd_Ex),     32'd31);
        chk("fl_cnt",   32'(stall_cnt), 32'd1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            drive(pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  pick_reg(), 1'($urandom_range(0, 1)),
                  pick_reg(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
            tick();
        end

        // saturation: a load that reads its own target stalls every other cycle
        drive(5'd5, 1, 1, 5'd5, 1, 5'd0, 0, 0);
        repeat (620) tick();
        chk("sat_cnt", 32'(stall_cnt), 32'd255);
        repeat (20) tick();
        chk("sat_hold", 32'(stall_cnt), 32'd255);

        // async reset while stalled
        drive(5'd5, 1, 1, 5'd0, 0, 5'd0, 0, 0);
        tick();
        drive(5'd8, 1, 0, 5'd5, 1, 5'd0, 0, 0);
        #1 chk("ar_pre_stall", 32'(stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_stall",  32'(stall),       32'd0);
        chk("ar_rd_ex",  32'(Rd_Ex),       32'd31);
        chk("ar_rd_mem", 32'(Rd_Mem),      32'd31);
        chk("ar_we_ex",  32'(writeEn_Ex),  32'd0);
        chk("ar_we_mem", 32'(writeEn_Mem), 32'd0);
        chk("ar_mr_ex",  32'(memRead_Ex),  32'd0);
        chk("ar_cnt",    32'(stall_cnt),   32'd0);
        tick();
        reset_n = 1'b1;
        drive(5'd12, 1, 0, 5'd0, 0, 5'd0, 0, 0);
        tick();
        chk("post_rst_rd_ex", 32'(Rd_Ex),      32'd12);
        chk("post_rst_we_ex", 32'(writeEn_Ex), 32'd1);
        tick();
        chk("post_rst_rd_mem", 32'(Rd_Mem), 32'd12);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
